// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI-style read channel pair (AR/R) among NREQ clients.
// Optional idle-beat watchdog is compiled in when RD_TIMEOUT_EN is defined (limit TMO_CYC cycles).
module axi_rd_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*4-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [NREQ-1:0]   cl_rvalid,
  output logic [7:0]        cl_rdata,
  output logic              cl_rresp,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [7:0]        ARADDR,
  output logic [3:0]        ARLEN,
  output logic [3:0]        ARID,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [7:0]        RDATA,
  input  logic              RRESP,
  input  logic              RLAST
);
  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  if (NREQ < 2 || NREQ > 4 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_param
    $error("axi_rd_arbiter: NREQ must be 2..4 and TMO_CYC 1..255");
  end

  logic [7:0] addr_a [NREQ];
  logic [3:0] len_a  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[8*g +: 8];
    assign len_a[g]  = req_len[4*g +: 4];
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, cl_rvalid_q, cl_rvalid_d;
  logic            err_q, err_d, cl_rresp_q, cl_rresp_d;
  logic [7:0]      cl_rdata_q, cl_rdata_d, araddr_q, araddr_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic [3:0]      arlen_q, arlen_d, arid_q, arid_d;
  logic [4:0]      beat_cnt_q, beat_cnt_d;
  logic            rerr_q, rerr_d;
`ifdef RD_TIMEOUT_EN
  logic [7:0]      tmo_q, tmo_d;
`endif

  // First requester strictly after the last winner, wrapping.
  int unsigned   cand;
  logic [IW-1:0] cand_idx, pick;
  logic          found;
  always_comb begin
    cand     = 0;
    cand_idx = '0;
    pick     = '0;
    found    = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand     = (32'(rr_q) + off) % NREQ;
      cand_idx = cand[IW-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  logic [IW-1:0] k;
  assign k = arid_q[IW-1:0];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    cl_rvalid_d = '0;
    cl_rdata_d  = cl_rdata_q;
    cl_rresp_d  = cl_rresp_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arid_d      = arid_q;
    rready_d    = rready_q;
    beat_cnt_d  = beat_cnt_q;
    rerr_d      = rerr_q;
`ifdef RD_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          araddr_d    = addr_a[pick];
          arlen_d     = len_a[pick];
          arid_d      = 4'(pick);
          arvalid_d   = 1'b1;
          rr_d        = pick;
          rerr_d      = 1'b0;
          state_d     = S_ADDR;
`ifdef RD_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      S_ADDR: begin
        if (ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          beat_cnt_d = '0;
          state_d    = S_DATA;
`ifdef RD_TIMEOUT_EN
          tmo_d      = '0;
        end else if (tmo_q == 8'(TMO_CYC - 1)) begin
          arvalid_d  = 1'b0;
          gnt_d      = '0;
          done_d[k]  = 1'b1;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d      = tmo_q + 8'd1;
`endif
        end
      end
      S_DATA: begin
        if (RVALID) begin
          cl_rvalid_d[k] = 1'b1;
          cl_rdata_d     = RDATA;
          cl_rresp_d     = RRESP;
          rerr_d         = rerr_q | RRESP;
          beat_cnt_d     = (beat_cnt_q == 5'd31) ? beat_cnt_q : beat_cnt_q + 5'd1;
`ifdef RD_TIMEOUT_EN
          tmo_d          = '0;
`endif
          // beat_cnt_q counts beats before this one, so a well-formed RLAST sees it equal ARLEN
          if (RLAST) begin
            rready_d  = 1'b0;
            gnt_d     = '0;
            done_d[k] = 1'b1;
            err_d     = (beat_cnt_q != {1'b0, arlen_q}) | rerr_q | RRESP;
            state_d   = S_IDLE;
          end
`ifdef RD_TIMEOUT_EN
        end else if (tmo_q == 8'(TMO_CYC - 1)) begin
          rready_d  = 1'b0;
          gnt_d     = '0;
          done_d[k] = 1'b1;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d     = tmo_q + 8'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_q        <= IW'(NREQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      cl_rvalid_q <= '0;
      cl_rdata_q  <= '0;
      cl_rresp_q  <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arid_q      <= '0;
      rready_q    <= 1'b0;
      beat_cnt_q  <= '0;
      rerr_q      <= 1'b0;
`ifdef RD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cl_rvalid_q <= cl_rvalid_d;
      cl_rdata_q  <= cl_rdata_d;
      cl_rresp_q  <= cl_rresp_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arid_q      <= arid_d;
      rready_q    <= rready_d;
      beat_cnt_q  <= beat_cnt_d;
      rerr_q      <= rerr_d;
`ifdef RD_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cl_rvalid = cl_rvalid_q;
  assign cl_rdata  = cl_rdata_q;
  assign cl_rresp  = cl_rresp_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign ARLEN     = arlen_q;
  assign ARID      = arid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: random clients and a random slave feed expectation queues
// that a monitor drains as the DUT presents grants, beats and done pulses.
module tb_axi_rd_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TMO  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ*4-1:0] req_len;
  logic [NREQ-1:0]   gnt, done, cl_rvalid;
  logic              err, cl_rresp;
  logic [7:0]        cl_rdata;
  logic              ARVALID, RREADY;
  logic              ARREADY = 1'b0;
  logic [7:0]        ARADDR;
  logic [3:0]        ARLEN, ARID;
  logic              RVALID = 1'b0, RRESP = 1'b0, RLAST = 1'b0;
  logic [7:0]        RDATA = '0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .gnt(gnt), .done(done), .err(err), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata),
    .cl_rresp(cl_rresp), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARID(ARID), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST)
  );

  typedef struct { logic [NREQ-1:0] v; logic [7:0] d; logic r; } beat_t;
  typedef struct { logic [NREQ-1:0] v; logic e; } done_t;
  beat_t beatq[$];
  done_t doneq[$];
  beat_t be;
  done_t de;

  int checks = 0;
  int errors = 0;

  logic [7:0] c_addr [NREQ];
  logic [3:0] c_len  [NREQ];
  int         cool   [NREQ];
  logic [NREQ-1:0] allow = '0;
  bit   first0 = 1'b1;
  bit   s_first = 1'b1;
  bit   stall = 1'b0;

  int              last_w, k_w, cur_k, cur_len;
  logic [NREQ-1:0] gnt_prev;
  int              s_state, s_nb, s_idx, s_gap, s_arw, r;
  bit              s_any;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[8*i +: 8] = c_addr[i];
      req_len[4*i +: 4]  = c_len[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: scan clients starting one past the last winner.
  function automatic int next_winner(input logic [NREQ-1:0] rq, input int last);
    for (int off = 1; off <= NREQ; off++)
      if (rq[(last + off) % NREQ]) return (last + off) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      beatq.delete();
      doneq.delete();
      last_w   = NREQ - 1;
      gnt_prev = '0;
      s_state  = 0;
      req      = '0;
      ARREADY  = 1'b0;
      RVALID   = 1'b0;
      RLAST    = 1'b0;
      RRESP    = 1'b0;
      RDATA    = '0;
      for (int i = 0; i < NREQ; i++) cool[i] = 0;
    end else begin
      // Arbitration: req as seen at the last rising edge is the current req value.
      if (gnt_prev == '0) begin
        if (req != '0) begin
          k_w = next_winner(req, last_w);
          chk("gnt", 32'(gnt), 32'(1) << k_w);
          chk("arvalid", 32'(ARVALID), 1);
          chk("araddr", 32'(ARADDR), 32'(c_addr[k_w]));
          chk("arlen", 32'(ARLEN), 32'(c_len[k_w]));
          chk("arid", 32'(ARID), 32'(k_w));
          last_w  = k_w;
          cur_k   = k_w;
          cur_len = int'(c_len[k_w]);
        end else if (gnt != '0) begin
          chk("gnt_idle", 32'(gnt), 0);
        end
      end

      if (cl_rvalid != '0) begin
        if (beatq.size() == 0) chk("beat_unexpected", 32'(cl_rvalid), 0);
        else begin
          be = beatq.pop_front();
          chk("beat_vld", 32'(cl_rvalid), 32'(be.v));
          chk("beat_data", 32'(cl_rdata), 32'(be.d));
          chk("beat_resp", 32'(cl_rresp), 32'(be.r));
        end
      end

      if (done != '0) begin
        if (doneq.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          de = doneq.pop_front();
          chk("done", 32'(done), 32'(de.v));
          chk("done_err", 32'(err), 32'(de.e));
          chk("done_released", {30'd0, gnt != '0, RREADY}, 0);
        end
        s_state = 0;
      end else if (err) begin
        chk("err_without_done", 32'(err), 0);
      end
      gnt_prev = gnt;

      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          req[i]  = 1'b0;
          cool[i] = $urandom_range(0, 3);
        end else if (!req[i] && allow[i]) begin
          if (cool[i] > 0) cool[i]--;
          else begin
            if (i == 0 && first0) begin
              c_addr[0] = 8'h40;
              c_len[0]  = 4'd3;
              first0    = 1'b0;
            end else begin
              c_addr[i] = 8'($urandom);
              c_len[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 3));
            end
            req[i] = 1'b1;
          end
        end
      end

      // Slave side
      RVALID = 1'b0;
      RLAST  = 1'b0;
      if (s_state == 1) begin
        chk("ar_handshake", {30'd0, ARVALID, RREADY}, 32'b01);
        ARREADY = 1'b0;
        r = $urandom_range(0, 5);
        if (s_first)                    s_nb = cur_len + 1;
        else if (r == 0 && cur_len > 0) s_nb = cur_len;
        else if (r == 1)                s_nb = cur_len + 2;
        else                            s_nb = cur_len + 1;
        s_idx = 0; s_any = 1'b0; s_gap = 0; s_state = 2;
`ifdef RD_TIMEOUT_EN
        if (stall) doneq.push_back('{v: NREQ'(1) << cur_k, e: 1'b1});
`endif
      end else if (s_state == 0 && ARVALID) begin
        if ($urandom_range(0, 1) == 1 || s_arw >= 3) begin
          ARREADY = 1'b1; s_state = 1; s_arw = 0;
        end else s_arw++;
      end

      if (s_state == 2 && !stall && RREADY && s_idx < s_nb) begin
        if ($urandom_range(0, 3) != 0 || s_gap >= 3) begin
          s_gap  = 0;
          RVALID = 1'b1;
          RDATA  = s_first ? 8'(8'hA1 + s_idx) : 8'($urandom);
          RRESP  = !s_first && ($urandom_range(0, 6) == 0);
          RLAST  = (s_idx == s_nb - 1);
          beatq.push_back('{v: NREQ'(1) << cur_k, d: RDATA, r: RRESP});
          s_any = s_any | RRESP;
          s_idx++;
          if (RLAST) begin
            doneq.push_back('{v: NREQ'(1) << cur_k, e: (s_nb != cur_len + 1) || s_any});
            s_state = 0;
            s_first = 1'b0;
          end
        end else s_gap++;
      end
    end
  end

  task automatic quiesce();
    allow = '0;
    for (int i = 0; i < 400 && !(gnt == '0 && req == '0 && beatq.size() == 0 && doneq.size() == 0); i++)
      @(negedge clk);
    chk("quiesce", {28'd0, gnt != '0, req != '0, beatq.size() != 0, doneq.size() != 0}, 0);
  endtask

  initial begin
    s_arw = 0;
    for (int i = 0; i < NREQ; i++) begin c_addr[i] = '0; c_len[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done_err", {29'd0, done, err}, 0);
    chk("rst_ar", {19'd0, ARVALID, ARADDR, ARLEN}, 0);
    chk("rst_arid_rready", {27'd0, ARID, RREADY}, 0);
    chk("rst_cl", {21'd0, cl_rvalid, cl_rdata, cl_rresp}, 0);
    #1 rst = 1'b1;
    allow = '1;
    repeat (4000) @(negedge clk);
    quiesce();

    // Reset while a burst is in its data phase
    allow = 2'b01;
    for (int i = 0; i < 100 && !RREADY; i++) @(negedge clk);
    chk("reach_data", 32'(RREADY), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_ctl", {30'd0, ARVALID, RREADY}, 0);
    chk("midrst_done", 32'(done), 0);
    allow = '1;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("post_rst_gnt", 32'(gnt), 1);
    quiesce();

    // Slave never returns data
    stall = 1'b1;
    allow = 2'b01;
    for (int i = 0; i < 100 && !(gnt != '0 && RREADY); i++) @(negedge clk);
    chk("stall_granted", {30'd0, gnt != '0, RREADY}, 32'b11);
    allow = '0;
`ifdef RD_TIMEOUT_EN
    for (int i = 0; i < 60 && doneq.size() != 0; i++) @(negedge clk);
    chk("tmo_done_seen", doneq.size(), 0);
    @(negedge clk);
    chk("tmo_released", {30'd0, gnt != '0, RREADY}, 0);
`else
    repeat (40) @(negedge clk);
    chk("stall_gnt", 32'(gnt), 1);
    chk("stall_rready", 32'(RREADY), 1);
    chk("stall_done", 32'(done), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
`endif
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("beatq_drained", beatq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
